// File: rtl/traffic_phase_timer.sv
// Two-way intersection phase sequencer. It times green, yellow and all-red phases on a 1 s tick.
// Each green length is latched from the demand inputs when that green is entered.
module traffic_phase_timer #(
  parameter int CNT_W      = 6,
  parameter int DEM_W      = 7,
  parameter int MIN_GREEN  = 24,
  parameter int MAX_GREEN  = 60,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [DEM_W-1:0] traffic_sec_ns,
  input  logic [DEM_W-1:0] traffic_sec_ew,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_done,
  output logic [CNT_W-1:0] green_len
);

  localparam int CW = (DEM_W > CNT_W) ? DEM_W : CNT_W;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] green_len_q, green_len_d;
  logic             phase_done_q, phase_done_d;
  logic [1:0]       ns_light_q, ns_light_d;
  logic [1:0]       ew_light_q, ew_light_d;

  state_e           next_state;
  logic [CNT_W-1:0] last_cnt;
  logic             hold;
  logic             illegal;

  // The demand is widened, not truncated, so 100 s still clamps to MAX_GREEN.
  function automatic logic [CNT_W-1:0] clamp_green(input logic [DEM_W-1:0] dem);
    logic [CW-1:0] wide;
    wide = CW'(dem);
    if (wide < CW'(MIN_GREEN)) begin
      return CNT_W'(MIN_GREEN);
    end else if (wide > CW'(MAX_GREEN)) begin
      return CNT_W'(MAX_GREEN);
    end
    return CNT_W'(wide);
  endfunction

  always_comb begin
    next_state = NS_GREEN;
    last_cnt   = '0;
    hold       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      NS_GREEN: begin
        next_state = NS_YELLOW;
        last_cnt   = green_len_q - CNT_W'(1);
        hold       = (traffic_sec_ew == '0);
      end
      NS_YELLOW: begin
        next_state = ALLRED_1;
        last_cnt   = CNT_W'(YELLOW_SEC - 1);
      end
      ALLRED_1: begin
        next_state = EW_GREEN;
        last_cnt   = CNT_W'(ALLRED_SEC - 1);
      end
      EW_GREEN: begin
        next_state = EW_YELLOW;
        last_cnt   = green_len_q - CNT_W'(1);
        hold       = (traffic_sec_ns == '0);
      end
      EW_YELLOW: begin
        next_state = ALLRED_2;
        last_cnt   = CNT_W'(YELLOW_SEC - 1);
      end
      ALLRED_2: begin
        next_state = NS_GREEN;
        last_cnt   = CNT_W'(ALLRED_SEC - 1);
      end
      default: illegal = 1'b1;
    endcase
  end

  // A held green parks at its last count, so the exit fires on the first tick after demand appears.
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    green_len_d  = green_len_q;
    phase_done_d = 1'b0;
    if (illegal) begin
      state_d     = NS_GREEN;
      phase_cnt_d = '0;
    end else if (tick) begin
      if (phase_cnt_q < last_cnt) begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
      end else if (!hold) begin
        state_d      = next_state;
        phase_cnt_d  = '0;
        phase_done_d = 1'b1;
        if (next_state == EW_GREEN) begin
          green_len_d = clamp_green(traffic_sec_ew);
        end else if (next_state == NS_GREEN) begin
          green_len_d = clamp_green(traffic_sec_ns);
        end
      end
    end
  end

  always_comb begin
    ns_light_d = LAMP_RED;
    ew_light_d = LAMP_RED;
    case (state_d)
      NS_GREEN:  ns_light_d = LAMP_GRN;
      NS_YELLOW: ns_light_d = LAMP_YEL;
      EW_GREEN:  ew_light_d = LAMP_GRN;
      EW_YELLOW: ew_light_d = LAMP_YEL;
      default: begin
        ns_light_d = LAMP_RED;
        ew_light_d = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NS_GREEN;
      phase_cnt_q  <= '0;
      green_len_q  <= CNT_W'(MIN_GREEN);
      phase_done_q <= 1'b0;
      ns_light_q   <= LAMP_GRN;
      ew_light_q   <= LAMP_RED;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      green_len_q  <= green_len_d;
      phase_done_q <= phase_done_d;
      ns_light_q   <= ns_light_d;
      ew_light_q   <= ew_light_d;
    end
  end

  assign phase      = state_q;
  assign phase_cnt  = phase_cnt_q;
  assign green_len  = green_len_q;
  assign phase_done = phase_done_q;
  assign ns_light   = ns_light_q;
  assign ew_light   = ew_light_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer. Directed and random steps run against a phase-table model
// that counts elapsed ticks per phase.
module tb_traffic_phase_timer;

  localparam int CNT_W = 6;
  localparam int DEM_W = 7;
  localparam int MIN_G = 24;
  localparam int MAX_G = 60;
  localparam int YEL   = 3;
  localparam int ARED  = 1;

  logic             clk;
  logic             rst;
  logic             tick;
  logic [DEM_W-1:0] dem_ns;
  logic [DEM_W-1:0] dem_ew;
  logic [1:0]       ns_light;
  logic [1:0]       ew_light;
  logic [2:0]       phase;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_done;
  logic [CNT_W-1:0] green_len;

  traffic_phase_timer #(
    .CNT_W(CNT_W), .DEM_W(DEM_W), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YELLOW_SEC(YEL), .ALLRED_SEC(ARED)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .traffic_sec_ns(dem_ns), .traffic_sec_ew(dem_ew),
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase),
    .phase_cnt(phase_cnt), .phase_done(phase_done), .green_len(green_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference: phase index 0..5 in cyclic order, ticks elapsed, latched green length.
  int   m_phase;
  int   m_cnt;
  int   m_glen;
  logic m_done;
  int   ns_lamp [0:5] = '{2, 1, 0, 0, 0, 0};
  int   ew_lamp [0:5] = '{0, 0, 0, 2, 1, 0};

  int prev_phase = 0;
  int n_changes  = 0;
  int n_pulses   = 0;

  function automatic int clamp_g(input int d);
    if (d < MIN_G) return MIN_G;
    if (d > MAX_G) return MAX_G;
    return d;
  endfunction

  function automatic int phase_len(input int p, input int glen);
    if (p == 0 || p == 3) return glen;
    if (p == 1 || p == 4) return YEL;
    return ARED;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic t, input int ns, input int ew);
    int  len;
    bit  held;
    m_done = 1'b0;
    if (r) begin
      m_phase = 0;
      m_cnt   = 0;
      m_glen  = MIN_G;
    end else if (t) begin
      len  = phase_len(m_phase, m_glen);
      held = (m_phase == 0 && ew == 0) || (m_phase == 3 && ns == 0);
      if (m_cnt + 1 < len) begin
        m_cnt++;
      end else if (held) begin
        m_cnt = len - 1;
      end else begin
        m_phase = (m_phase + 1) % 6;
        m_cnt   = 0;
        m_done  = 1'b1;
        if (m_phase == 3) m_glen = clamp_g(ew);
        if (m_phase == 0) m_glen = clamp_g(ns);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input int ns, input int ew);
    rst    = r;
    tick   = t;
    dem_ns = DEM_W'(ns);
    dem_ew = DEM_W'(ew);
    @(posedge clk);
    model_step(r, t, ns, ew);
    #1;
    checkOutput("phase", 32'(phase), 32'(m_phase));
    checkOutput("phase_cnt", 32'(phase_cnt), 32'(m_cnt));
    checkOutput("green_len", 32'(green_len), 32'(m_glen));
    checkOutput("phase_done", 32'(phase_done), 32'(m_done));
    checkOutput("ns_light", 32'(ns_light), 32'(ns_lamp[m_phase]));
    checkOutput("ew_light", 32'(ew_light), 32'(ew_lamp[m_phase]));
    checkOutput("lamp_exclusive", 32'(ns_light != 2'b00 && ew_light != 2'b00), 32'd0);
    if (!r && int'(phase) != prev_phase) n_changes++;
    if (phase_done) n_pulses++;
    prev_phase = int'(phase);
  endtask

  task automatic runUntil(input int ph, input int cnt, input int budget,
                          input int ns, input int ew, input string tag);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == ph && (cnt < 0 || m_cnt == cnt)) begin
        reached = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b1, ns, ew);
    end
    checkOutput(tag, 32'(reached), 32'd1);
  endtask

  initial begin
    int ns_r;
    int ew_r;
    int frozen_cnt;
    int ew_ticks;
    rst = 1'b1; tick = 1'b0; dem_ns = '0; dem_ew = '0;

    $display("[TB] reset and nominal cycle");
    applyStimulus(1'b1, 1'b0, 10, 30);
    applyStimulus(1'b1, 1'b1, 10, 30);
    checkOutput("reset_green_len", 32'(green_len), 32'(MIN_G));
    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b1, 10, 30);

    $display("[TB] clamp high/low");
    applyStimulus(1'b1, 1'b0, 10, 100);
    runUntil(3, 0, 200, 10, 100, "reach_ew_green_hi");
    checkOutput("clamp_hi", 32'(green_len), 32'd60);
    ew_ticks = 0;
    while (phase == 3'd3 && ew_ticks < 100) begin
      applyStimulus(1'b0, 1'b1, 10, 5);
      ew_ticks++;
    end
    checkOutput("ew_green_ticks", 32'(ew_ticks), 32'd60);
    runUntil(3, 0, 200, 10, 5, "reach_ew_green_lo");
    checkOutput("clamp_lo", 32'(green_len), 32'd24);

    $display("[TB] green hold");
    applyStimulus(1'b1, 1'b0, 17, 0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 17, 0);
    checkOutput("hold_cnt", 32'(phase_cnt), 32'd23);
    checkOutput("hold_phase", 32'(phase), 32'd0);
    applyStimulus(1'b0, 1'b0, 17, 8);
    applyStimulus(1'b0, 1'b1, 17, 8);
    checkOutput("hold_exit", 32'(phase), 32'd1);

    $display("[TB] tick freeze in EW yellow");
    runUntil(4, 1, 200, 17, 8, "reach_ew_yellow");
    frozen_cnt = m_cnt;
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, $urandom_range(0, 127), $urandom_range(0, 127));
    checkOutput("freeze_cnt", 32'(phase_cnt), 32'(frozen_cnt));
    checkOutput("freeze_phase", 32'(phase), 32'd4);

    $display("[TB] reset overrides");
    runUntil(4, 2, 300, 17, 8, "reach_ew_yellow_2");
    applyStimulus(1'b1, 1'b1, 17, 8);
    checkOutput("rst_mid_yellow", 32'(phase), 32'd0);
    runUntil(2, 0, 300, 17, 8, "reach_allred");
    applyStimulus(1'b1, 1'b1, 17, 8);
    checkOutput("rst_on_transition", 32'(phase_cnt), 32'd0);
    runUntil(1, 0, 300, 17, 8, "reach_done_cycle");
    checkOutput("done_seen", 32'(phase_done), 32'd1);
    applyStimulus(1'b1, 1'b1, 17, 8);
    checkOutput("rst_after_done", 32'(phase_done), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      ns_r = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 127);
      ew_r = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 127);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ns_r, ew_r);
    end

    checkOutput("done_vs_changes", 32'(n_pulses), 32'(n_changes));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
